// File: rtl/bcd_display_seq.sv
// Iterative double-dabble binary-to-BCD converter driving DIGITS active-low 7-segment displays.
// One shift/add-3 step per clock; start is taken in IDLE/DONE, done pulses one cycle after step WIDTH.
module bcd_display_seq #(
    parameter int WIDTH         = 7,
    parameter int DIGITS        = 2,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      num,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int XW = (WIDTH > 64) ? WIDTH : 64;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Overflow threshold 10**DIGITS; exact for DIGITS <= 19.
    localparam logic [XW-1:0] LIMIT = XW'(pow10(DIGITS));

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    function automatic logic [SW-1:0] render(input logic [BW-1:0] b, input logic ovf);
        logic [SW-1:0] s;
        logic          lead;
        s    = '0;
        lead = 1'b1;
        // lead stays set while every digit from the top down to k is zero
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead = lead && (b[4*k +: 4] == 4'd0);
            if (ovf) begin
                s[7*k +: 7] = 7'b0111111;
            end else if (BLANK_LEADING && lead && (k != 0)) begin
                s[7*k +: 7] = 7'b1111111;
            end else begin
                s[7*k +: 7] = dec7(b[4*k +: 4]);
            end
        end
        return s;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   work_q, work_d;
    logic            ovf_q, ovf_d;
    logic            overflow_q, overflow_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [SW-1:0]   seg_q, seg_d;

    logic [XW-1:0]   num_ext;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;

    assign num_ext = XW'(num);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        work_d     = work_q;
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        seg_d      = seg_q;

        adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
        // The carry out of the top digit is dropped: only the low DIGITS digits are kept.
        shifted = BW'({adj, bin_q[WIDTH-1]});

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bin_d   = num;
                    work_d  = '0;
                    ovf_d   = (num_ext >= LIMIT);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                bin_d  = bin_q << 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d    = ST_DONE;
                    bcd_d      = shifted;
                    seg_d      = render(shifted, ovf_q);
                    overflow_d = ovf_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            work_q     <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            seg_q      <= render('0, 1'b0);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
            seg_q      <= seg_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign overflow = overflow_q;
    assign bcd      = bcd_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_bcd_display_seq.sv
// Randomised scoreboard bench for bcd_display_seq (WIDTH=7, DIGITS=2), blanking and non-blanking
// instances side by side; expectations come from decimal arithmetic on the captured value.
module tb_bcd_display_seq;
    localparam int W = 7;
    localparam int D = 2;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        logic [7:0]  bcd;
        logic [13:0] seg;
        logic [13:0] seg_b;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  num;
    logic        busy, done, overflow;
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic        busy_b, done_b, overflow_b;
    logic [7:0]  bcd_b;
    logic [13:0] seg_b;

    bcd_display_seq #(.WIDTH(W), .DIGITS(D), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num(num),
        .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .seg(seg)
    );

    bcd_display_seq #(.WIDTH(W), .DIGITS(D), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .num(num),
        .busy(busy_b), .done(done_b), .overflow(overflow_b), .bcd(bcd_b), .seg(seg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rem = 0;
    int   epoch = 0;
    int   pushed = 0;
    int   ndone = 0;
    int   seen_epoch = 0;
    bit   final_req = 1'b0;
    bit   final_ack = 1'b0;
    exp_t exp_q[$];
    exp_t hold;
    exp_t e;

    function automatic exp_t predict(input int v, input int due);
        exp_t r;
        int   d0;
        int   d1;
        d0    = v % 10;
        d1    = (v / 10) % 10;
        r.ovf = (v >= 100);
        r.bcd = {4'(d1), 4'(d0)};
        if (r.ovf) begin
            r.seg   = {DASH, DASH};
            r.seg_b = {DASH, DASH};
        end else begin
            r.seg   = {(d1 == 0) ? BLANK : SEG_TAB[d1], SEG_TAB[d0]};
            r.seg_b = {SEG_TAB[d1], SEG_TAB[d0]};
        end
        r.due = due;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference timing: a request is accepted whenever no conversion is outstanding.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pushed -= exp_q.size();
            exp_q.delete();
            rem = 0;
            epoch++;
        end else if (rem == 0) begin
            if (start) begin
                exp_q.push_back(predict(int'(num), cyc + W));
                pushed++;
                rem = W;
            end
        end else begin
            rem--;
        end
    end

    always @(negedge clk) begin
        if (epoch > 0) begin
            logic exp_done;
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                hold       = predict(0, 0);
            end
            exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("busy", 32'(busy), 32'(rem > 0));
            chk("busy_nb", 32'(busy_b), 32'(rem > 0));
            chk("done", 32'(done), 32'(exp_done));
            chk("done_nb", 32'(done_b), 32'(exp_done));
            if (exp_done) begin
                e    = exp_q.pop_front();
                hold = e;
                if (done) ndone++;
            end
            chk("bcd", 32'(bcd), 32'(hold.bcd));
            chk("seg", 32'(seg), 32'(hold.seg));
            chk("overflow", 32'(overflow), 32'(hold.ovf));
            chk("bcd_nb", 32'(bcd_b), 32'(hold.bcd));
            chk("seg_nb", 32'(seg_b), 32'(hold.seg_b));
            chk("overflow_nb", 32'(overflow_b), 32'(hold.ovf));
            if (final_req && !final_ack) begin
                chk("drain", 32'(exp_q.size()), 32'd0);
                chk("done_count", 32'(ndone), 32'(pushed));
                final_ack = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (rem != 0 || exp_q.size() != 0); i++) tick();
        tick();
    endtask

    task automatic send(input int v);
        num   = 7'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        num   = 7'($urandom_range(0, 127));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        send(42);  wait_idle();
        send(120); wait_idle();
        send(99);  wait_idle();
        send(5);   wait_idle();
        send(0);   wait_idle();
        send(100); wait_idle();
        send(127); wait_idle();

        // second start while converting must be ignored
        send(63);
        tick();
        tick();
        num   = 7'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();

        // reset during the third SHIFT cycle aborts the request
        send(88);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();

        // back-to-back sweep with start held high
        start = 1'b1;
        for (int v = 0; v < 128; v++) begin
            num = 7'(v);
            repeat (W + 1) tick();
        end
        start = 1'b0;
        wait_idle();

        repeat (300) begin
            num   = 7'($urandom_range(0, 127));
            start = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 80) != 0);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        wait_idle();

        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_ack; i++) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
